// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and lane enables.
package mem_stage_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      MEM_SIZE_BYTE: be = BE_BYTE0 << addr_lo;
      MEM_SIZE_HALF: be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      MEM_SIZE_WORD: be = BE_WORD;
      default:       be = BE_NONE;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Extracts the addressed byte/half lane from a read word and sign- or zero-extends it.
module load_formatter
  import mem_stage_pkg::*;
(
  input  logic [31:0] read_data_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_extend_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = read_data_i[7:0];
    case (addr_i)
      2'd1:    byte_lane = read_data_i[15:8];
      2'd2:    byte_lane = read_data_i[23:16];
      2'd3:    byte_lane = read_data_i[31:24];
      default: byte_lane = read_data_i[7:0];
    endcase
    half_lane = addr_i[1] ? read_data_i[31:16] : read_data_i[15:0];
  end

  always_comb begin
    case (size_i)
      MEM_SIZE_BYTE: load_data_o = {{24{sign_extend_i & byte_lane[7]}}, byte_lane};
      MEM_SIZE_HALF: load_data_o = {{16{sign_extend_i & half_lane[15]}}, half_lane};
      default:       load_data_o = read_data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data bus, lane formatting, pipeline stall.
// state | meaning
// IDLE  | no access outstanding; a clean access issues the bus request
// WAIT  | request held stable until busAcknowledge
// DONE  | access complete, pipeline advances; never re-issues
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic        valid,
  input  logic [31:0] aluOutput,
  input  logic [31:0] registerRtOrZero,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSignExtend,
  output logic        busRequest,
  output logic        busWrite,
  output logic [31:0] busAddress,
  output logic [31:0] busWriteData,
  output logic [3:0]  busByteEnable,
  input  logic [31:0] busReadData,
  input  logic        busAcknowledge,
  output logic        stall,
  output logic        misalignedFault,
  output logic [31:0] stageOutput
);

  state_e      state_q;
  logic        bus_request_q;
  logic        bus_write_q;
  logic [31:0] bus_address_q;
  logic [31:0] bus_write_data_q;
  logic [3:0]  bus_byte_enable_q;
  logic [31:0] load_data_q;

  logic        mem_op;
  logic        size_fault;
  logic        fault;
  logic        access;
  logic [31:0] store_data_d;
  logic [31:0] load_fmt;

  assign mem_op = valid & (memRead | memWrite);

  always_comb begin
    case (memSize)
      MEM_SIZE_BYTE: size_fault = 1'b0;
      MEM_SIZE_HALF: size_fault = aluOutput[0];
      MEM_SIZE_WORD: size_fault = |aluOutput[1:0];
      default:       size_fault = 1'b1;
    endcase
  end

  assign fault  = mem_op & size_fault;
  assign access = mem_op & ~fault;

  always_comb begin
    case (memSize)
      MEM_SIZE_BYTE: store_data_d = {4{registerRtOrZero[7:0]}};
      MEM_SIZE_HALF: store_data_d = {2{registerRtOrZero[15:0]}};
      default:       store_data_d = registerRtOrZero;
    endcase
  end

  // EX/MEM is frozen while stalled, so the live inputs still describe the access at ack time.
  load_formatter u_load_formatter (
    .read_data_i   (busReadData),
    .addr_i        (aluOutput[1:0]),
    .size_i        (memSize),
    .sign_extend_i (memSignExtend),
    .load_data_o   (load_fmt)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q           <= IDLE;
      bus_request_q     <= 1'b0;
      bus_write_q       <= 1'b0;
      bus_address_q     <= '0;
      bus_write_data_q  <= '0;
      bus_byte_enable_q <= BE_NONE;
      load_data_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q           <= WAIT;
            bus_request_q     <= 1'b1;
            bus_write_q       <= memWrite;
            bus_address_q     <= {aluOutput[31:2], 2'b00};
            bus_write_data_q  <= store_data_d;
            bus_byte_enable_q <= lane_enables(memSize, aluOutput[1:0]);
          end
        end
        WAIT: begin
          if (busAcknowledge) begin
            state_q       <= DONE;
            bus_request_q <= 1'b0;
            if (!bus_write_q) load_data_q <= load_fmt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busRequest      = bus_request_q;
  assign busWrite        = bus_write_q;
  assign busAddress      = bus_address_q;
  assign busWriteData    = bus_write_data_q;
  assign busByteEnable   = bus_byte_enable_q;
  assign misalignedFault = fault;
  assign stall           = ((state_q == IDLE) & access) | (state_q == WAIT);
  assign stageOutput     = ((state_q == DONE) & memRead) ? load_data_q : aluOutput;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: byte-level memory model, random-latency responder, bus and retire monitors.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        resetN;
  logic        valid;
  logic [31:0] aluOutput;
  logic [31:0] registerRtOrZero;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memSignExtend;
  logic        busRequest;
  logic        busWrite;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic [3:0]  busByteEnable;
  logic [31:0] busReadData;
  logic        busAcknowledge;
  logic        stall;
  logic        misalignedFault;
  logic [31:0] stageOutput;

  mem_stage dut (
    .clock(clock), .resetN(resetN), .valid(valid), .aluOutput(aluOutput),
    .registerRtOrZero(registerRtOrZero), .memRead(memRead), .memWrite(memWrite),
    .memSize(memSize), .memSignExtend(memSignExtend), .busRequest(busRequest),
    .busWrite(busWrite), .busAddress(busAddress), .busWriteData(busWriteData),
    .busByteEnable(busByteEnable), .busReadData(busReadData),
    .busAcknowledge(busAcknowledge), .stall(stall), .misalignedFault(misalignedFault),
    .stageOutput(stageOutput)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] out; logic flt; int stalls; } res_t;
  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  int   delay_q[$];

  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];
  logic [31:0] last_load;

  int n_cmp = 0;
  int n_bad = 0;
  int req_seen = 0;
  int req_expected = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int unsigned a);
    logic [31:0] t;
    t = (a * 37) ^ (a >> 2) ^ 32'h5A;
    return t[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] bus_rd(input int unsigned aw);
    return bus_mem.exists(aw) ? bus_mem[aw]
         : {init_byte(aw + 3), init_byte(aw + 2), init_byte(aw + 1), init_byte(aw)};
  endfunction

  task automatic preload(input int unsigned aw, input logic [31:0] w);
    bus_mem[aw] = w;
    for (int i = 0; i < 4; i++) ref_mem[aw + i] = w[8*i +: 8];
  endtask

  // Reference: compute everything an instruction should produce, queue it, then drive it.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] rt, input int delay);
    int nb;
    logic flt, acc;
    logic [31:0] v, mask, exp_out;
    bus_t b;
    res_t r;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    flt = (rd | wr) && (size == 2'd3 || (addr % nb) != 0);
    acc = (rd | wr) && !flt;
    exp_out = addr;
    if (acc) begin
      delay_q.push_back(delay);
      req_expected++;
      b.wr    = wr;
      b.addr  = addr & ~32'd3;
      b.be    = 4'(((1 << nb) - 1) << (addr % 4));
      b.wdata = (nb == 1) ? rt[7:0] * 32'h01010101 : (nb == 2) ? rt[15:0] * 32'h00010001 : rt;
      bus_q.push_back(b);
      if (wr) begin
        for (int i = 0; i < nb; i++) ref_mem[addr + i] = rt[8*i +: 8];
        if (rd) exp_out = last_load;
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v |= 32'(ref_rd(addr + i)) << (8 * i);
        mask = (nb == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * nb)) - 1;
        if (sext && nb < 4 && v[8*nb-1]) v |= ~mask;
        last_load = v;
        exp_out = v;
      end
    end
    r.out = exp_out; r.flt = flt; r.stalls = acc ? delay + 2 : 0;
    res_q.push_back(r);
    valid = 1'b1; memRead = rd; memWrite = wr; memSize = size; memSignExtend = sext;
    aluOutput = addr; registerRtOrZero = rt;
    begin : wait_retire
      for (int k = 0; k < 60; k++) begin
        @(negedge clock);
        if (!stall) disable wait_retire;
      end
      n_cmp++; n_bad++;
      $display("FAIL retire_timeout: stall still %b after 60 cycles, expected 0", stall);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle_cycle();
    valid = 1'b0; memRead = 1'($urandom); memWrite = 1'($urandom); memSize = 2'($urandom);
    aluOutput = $urandom; registerRtOrZero = $urandom;
    @(posedge clock); #1;
  endtask

  // Retire monitor: counts stall cycles per instruction and pops the result scoreboard.
  int stall_cnt = 0;
  always @(negedge clock) begin
    if (!resetN) stall_cnt = 0;
    else if (valid) begin
      if (stall) stall_cnt++;
      else if (res_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL retire_unexpected: got retirement, expected none");
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("stage_output", stageOutput, r.out);
        check("misaligned_fault", 32'(misalignedFault), 32'(r.flt));
        check("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
        stall_cnt = 0;
      end
    end else begin
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_fault", 32'(misalignedFault), 32'd0);
    end
  end

  // Bus monitor: first cycle of a request pops the bus scoreboard, later cycles must be stable.
  logic req_prev = 1'b0;
  bus_t snap;
  always @(negedge clock) begin
    if (busRequest && !req_prev) begin
      req_seen++;
      if (bus_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL bus_unexpected: got request at %h, expected none", busAddress);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        check("bus_write", 32'(busWrite), 32'(b.wr));
        check("bus_address", busAddress, b.addr);
        check("bus_byte_enable", 32'(busByteEnable), 32'(b.be));
        if (b.wr) check("bus_write_data", busWriteData, b.wdata);
      end
      snap.wr = busWrite; snap.addr = busAddress; snap.wdata = busWriteData; snap.be = busByteEnable;
    end else if (busRequest) begin
      check("bus_stable_addr", busAddress, snap.addr);
      check("bus_stable_data", busWriteData, snap.wdata);
      check("bus_stable_ctl", {27'd0, busWrite, busByteEnable}, {27'd0, snap.wr, snap.be});
    end
    req_prev = busRequest;
  end

  // Responder: acks after the queued delay; random stray acks while no request is outstanding.
  initial begin
    bit inflight;
    int cnt;
    inflight = 0; cnt = 0;
    busAcknowledge = 1'b0; busReadData = '0;
    forever begin
      @(posedge clock); #2;
      if (!busRequest) begin
        inflight = 0;
        busAcknowledge = ($urandom_range(0, 3) == 0);
        busReadData = $urandom;
      end else begin
        if (!inflight) begin
          inflight = 1;
          cnt = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
        end
        if (cnt == 0) begin
          busAcknowledge = 1'b1;
          if (busWrite) begin
            logic [31:0] w;
            w = bus_rd(busAddress);
            for (int i = 0; i < 4; i++) if (busByteEnable[i]) w[8*i +: 8] = busWriteData[8*i +: 8];
            bus_mem[busAddress] = w;
            busReadData = $urandom;
          end else busReadData = bus_rd(busAddress);
          cnt = -1;
        end else begin
          busAcknowledge = 1'b0;
          if (cnt > 0) cnt--;
        end
      end
    end
  end

  initial begin
    resetN = 1'b0; valid = 1'b0; memRead = 1'b1; memWrite = 1'b0; memSize = 2'd2;
    memSignExtend = 1'b0; aluOutput = 32'h1234; registerRtOrZero = 32'hFFFF_FFFF;
    last_load = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_bus_request", 32'(busRequest), 32'd0);
    check("rst_bus_write", 32'(busWrite), 32'd0);
    check("rst_bus_address", busAddress, 32'd0);
    check("rst_bus_write_data", busWriteData, 32'd0);
    check("rst_bus_byte_enable", 32'(busByteEnable), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_stage_output", stageOutput, 32'h1234);
    resetN = 1'b1;
    @(posedge clock); #1;

    preload(32'h100, 32'hDEADBEEF);
    issue(1, 0, 2'd2, 0, 32'h100, 32'h0, 0);
    preload(32'h200, 32'h80FF_FF7F);
    issue(1, 0, 2'd0, 1, 32'h203, 32'h0, 1);
    issue(1, 0, 2'd0, 0, 32'h203, 32'h0, 0);
    issue(0, 1, 2'd1, 0, 32'h12, 32'h0000_ABCD, 3);
    issue(1, 0, 2'd2, 0, 32'h102, 32'h0, 0);
    issue(1, 0, 2'd2, 0, 32'h100, 32'h0, 0);
    issue(0, 0, 2'd0, 0, 32'h55, 32'h0, 0);
    issue(1, 0, 2'd1, 1, 32'h202, 32'h0, 2);
    issue(1, 1, 2'd2, 0, 32'h104, 32'hCAFE_F00D, 1);
    issue(1, 0, 2'd3, 0, 32'h108, 32'h0, 0);
    issue(1, 0, 2'd1, 0, 32'h10, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      int kind;
      logic rd, wr;
      kind = $urandom_range(0, 7);
      rd = (kind <= 3) || (kind == 6);
      wr = (kind >= 4 && kind <= 6);
      issue(rd, wr, 2'($urandom), 1'($urandom), 32'h300 + ($urandom % 64), $urandom,
            $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    // Abandon an access mid-WAIT with reset.
    delay_q.push_back(20);
    req_expected++;
    bus_q.push_back('{wr: 1'b0, addr: 32'h40, wdata: 32'h0, be: 4'hF});
    valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; memSize = 2'd2; aluOutput = 32'h40;
    begin : wait_req
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        if (busRequest) disable wait_req;
      end
      n_cmp++; n_bad++;
      $display("FAIL reset_req_timeout: busRequest never rose, expected 1");
    end
    #2;
    resetN = 1'b0; valid = 1'b0;
    #1;
    check("reset_drop_request", 32'(busRequest), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    last_load = '0;
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    memRead = 1'b1; memSize = 2'd2; aluOutput = 32'h40;
    repeat (4) begin
      @(negedge clock);
      check("post_reset_stall", 32'(stall), 32'd0);
      check("post_reset_request", 32'(busRequest), 32'd0);
    end
    @(posedge clock); #1;
    issue(1, 0, 2'd2, 0, 32'h44, 32'h0, 1);
    repeat (5) idle_cycle();

    check("res_queue_drained", 32'(res_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    check("request_count", 32'(req_seen), 32'(req_expected));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
